// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls in, instruction memory port,
// and the IF/ID pipeline register handed to decode.
interface instr_fetch_if #(
  parameter int PC_W    = 14,
  parameter int INSTR_W = 32
);
  logic               stall_IF_ID;
  logic               flow_change_ID_EX;
  logic [PC_W-1:0]    dst_ID_EX;
  logic               hlt_ID;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    iaddr;
  logic               rd_en;
  logic [INSTR_W-1:0] instr_IF_ID;
  logic [PC_W-1:0]    pc_IF_ID;
  logic               vld_IF_ID;
  logic               halted;

  // Pipeline / memory side that drives the fetch stage.
  modport master (
    output stall_IF_ID, flow_change_ID_EX, dst_ID_EX, hlt_ID, instr,
    input  iaddr, rd_en, instr_IF_ID, pc_IF_ID, vld_IF_ID, halted
  );

  // The fetch stage itself.
  modport slave (
    input  stall_IF_ID, flow_change_ID_EX, dst_ID_EX, hlt_ID, instr,
    output iaddr, rd_en, instr_IF_ID, pc_IF_ID, vld_IF_ID, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the falling-edge instruction
// memory and loads the IF/ID register, with redirect > stall > halt priority.
module instr_fetch #(
  parameter int                 PC_W      = 14,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic        clk,
  input  logic        rst,
  instr_fetch_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               vld_q;
  logic               halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_q     <= '0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // A resolved branch is older than whatever decode holds, so it
          // beats both the stall and a (wrong-path) halt.
          if (bus.flow_change_ID_EX) begin
            pc      <= bus.dst_ID_EX;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            vld_q   <= 1'b0;
          end else if (bus.stall_IF_ID) begin
            pc      <= pc;
          end else if (bus.hlt_ID) begin
            state    <= HALTED;
            halted_q <= 1'b1;
            instr_q  <= NOP_INSTR;
            vld_q    <= 1'b0;
          end else begin
            instr_q <= bus.instr;
            pc_q    <= pc + PC_ONE;
            vld_q   <= 1'b1;
            pc      <= pc + PC_ONE;
          end
        end
        HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // The memory keeps its last word while rd_en is low, which is what makes
  // a stall replay-free on resume.
  assign bus.rd_en       = ~rst & ~bus.stall_IF_ID & ~halted_q;
  assign bus.iaddr       = pc;
  assign bus.instr_IF_ID = instr_q;
  assign bus.pc_IF_ID    = pc_q;
  assign bus.vld_IF_ID   = vld_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: falling-edge memory model, directed scenarios and a
// random tail checked against a rule-level reference of the fetch stage.
module tb_instr_fetch;
  localparam int PC_W    = 14;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 1 << PC_W;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [INSTR_W-1:0] mem [DEPTH];

  // reference state
  int                 e_pc;
  int                 e_pcq;
  logic [INSTR_W-1:0] e_instr;
  bit                 e_vld;
  bit                 e_halted;

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(14'd0), .NOP_INSTR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.rd_en) bus.instr <= mem[bus.iaddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, check rd_en, advance reference, check registers.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [PC_W-1:0] d, input logic h);
    rst = r;
    bus.stall_IF_ID       = s;
    bus.flow_change_ID_EX = f;
    bus.dst_ID_EX         = d;
    bus.hlt_ID            = h;
    #1;
    chk("rd_en", {31'd0, bus.rd_en}, {31'd0, (!r && !s && !e_halted)});
    @(posedge clk);
    if (r) begin
      e_pc = 0; e_instr = '0; e_pcq = 0; e_vld = 0; e_halted = 0;
    end else if (!e_halted) begin
      if (f) begin
        e_pc = int'(d); e_instr = '0; e_vld = 0; e_pcq = 0;
      end else if (!s) begin
        if (h) begin
          e_halted = 1; e_instr = '0; e_vld = 0;
        end else begin
          e_instr = mem[e_pc];
          e_pc    = (e_pc + 1) % DEPTH;
          e_pcq   = e_pc;
          e_vld   = 1;
        end
      end
    end
    #1;
    chk("iaddr",  {18'd0, bus.iaddr},    e_pc);
    chk("instr",  bus.instr_IF_ID,       e_instr);
    chk("pc_q",   {18'd0, bus.pc_IF_ID}, e_pcq);
    chk("vld",    {31'd0, bus.vld_IF_ID}, {31'd0, e_vld});
    chk("halted", {31'd0, bus.halted},   {31'd0, e_halted});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 64 && e_pc != target; i++) step(0, 0, 0, '0, 0);
    chk("run_to", {18'd0, bus.iaddr}, target);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    e_pc = 0; e_pcq = 0; e_instr = '0; e_vld = 0; e_halted = 0;

    // reset release and first fetches
    do_reset();
    chk("rst_vld", {31'd0, bus.vld_IF_ID}, 32'd0);
    step(0, 0, 0, '0, 0);
    chk("tp1_i0", bus.instr_IF_ID, 32'h1111_1111);
    chk("tp1_p0", {18'd0, bus.pc_IF_ID}, 32'd1);
    step(0, 0, 0, '0, 0);
    chk("tp1_i1", bus.instr_IF_ID, 32'h2222_2222);
    step(0, 0, 0, '0, 0);
    chk("tp1_i2", bus.instr_IF_ID, 32'h3333_3333);
    chk("tp1_p2", {18'd0, bus.pc_IF_ID}, 32'd3);

    // 3-cycle stall at PC=5
    run_to(5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 0);
    chk("stall_iaddr", {18'd0, bus.iaddr}, 32'd5);
    chk("stall_pcq", {18'd0, bus.pc_IF_ID}, 32'd5);
    chk("stall_instr", bus.instr_IF_ID, mem[4]);
    step(0, 0, 0, '0, 0);
    chk("resume_instr", bus.instr_IF_ID, mem[5]);

    // redirect at PC=7, alone then together with a stall
    for (int k = 0; k < 2; k++) begin
      do_reset();
      run_to(7);
      step(0, k[0], 1, 14'h0100, 0);
      chk("redir_iaddr", {18'd0, bus.iaddr}, 32'h100);
      chk("redir_vld", {31'd0, bus.vld_IF_ID}, 32'd0);
      step(0, 0, 0, '0, 0);
      chk("redir_instr", bus.instr_IF_ID, mem[14'h100]);
      chk("redir_pcq", {18'd0, bus.pc_IF_ID}, 32'h101);
    end

    // halt at PC=9, redirect ignored, reset exits
    do_reset();
    run_to(9);
    step(0, 0, 0, '0, 1);
    chk("hlt_halted", {31'd0, bus.halted}, 32'd1);
    step(0, 0, 1, 14'h0020, 0);
    step(0, 1, 0, '0, 0);
    run(2);
    chk("hlt_iaddr", {18'd0, bus.iaddr}, 32'd9);
    step(1, 0, 0, '0, 0);
    chk("hlt_rst_iaddr", {18'd0, bus.iaddr}, 32'd0);
    chk("hlt_rst_halted", {31'd0, bus.halted}, 32'd0);

    // halt on the wrong path of a redirect
    run(3);
    step(0, 0, 1, 14'h0040, 1);
    chk("hltfc_halted", {31'd0, bus.halted}, 32'd0);
    chk("hltfc_iaddr", {18'd0, bus.iaddr}, 32'h40);
    run(2);

    // PC wrap, then reset during a stall
    step(0, 0, 1, 14'h3FFF, 0);
    step(0, 0, 0, '0, 0);
    chk("wrap_instr", bus.instr_IF_ID, mem[14'h3FFF]);
    chk("wrap_pcq", {18'd0, bus.pc_IF_ID}, 32'd0);
    chk("wrap_iaddr", {18'd0, bus.iaddr}, 32'd0);
    run(2);
    step(0, 1, 0, '0, 0);
    step(1, 1, 0, '0, 0);
    chk("rst_stall_iaddr", {18'd0, bus.iaddr}, 32'd0);
    chk("rst_stall_vld", {31'd0, bus.vld_IF_ID}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) < 3, $urandom_range(99) < 20,
           $urandom_range(99) < 10, PC_W'($urandom_range(DEPTH - 1)),
           $urandom_range(99) < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
